fc_param_load_ctrl: RTL
=======================

Name: fc_param_load_ctrl

Overview:
- Sequences loading of FC-layer parameters (bias, then weights, per layer) from a 16-bit word stream into the byte-wide parameter RAM.
- Accepts words over a valid/ready handshake and splits each word into two byte writes, low byte first.
- Tracks the current layer and region (bias or weights), generates RAM addresses, and flags load completion so compute can start.
- Sits between the parameter source (bench file reader or host) and the parameter RAM write port.

Parameters:
- NUM_LAYERS, 2, number of FC layers to load.
- BIAS_WORDS, 10, 16-bit bias words per layer (>=1).
- WEIGHT_WORDS, 100, 16-bit weight words per layer (>=1).
- ADDR_W, 16, RAM byte-address width.
- BASE_ADDR, 0, byte address of the first parameter byte.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a full load; ignored unless in IDLE.
- abort  in  1  synchronous abort; return to IDLE on the next edge, no done.
- in_data  in  16  parameter word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a word.
- ram_we  out  1  RAM byte write strobe.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_data  out  8  RAM write byte.
- load  out  1  high while a load is in progress.
- layer_idx  out  8  current layer, 0..NUM_LAYERS-1.
- region  out  1  0 = bias, 1 = weights.
- done  out  1  one-cycle pulse when the last byte has been written.
- checksum  out  16  parameter checksum (see Optional Feature).

Behaviour:
- Reset (RST=0, asynchronous): state IDLE. All outputs 0. Pointer is set to BASE_ADDR. All counters are 0.
- States:
  - IDLE: start moves to WAIT_WORD. On that transition, set load=1, ptr=BASE_ADDR, layer_idx=0, region=0, word_cnt=0.
  - WAIT_WORD: in_ready=1. On in_valid&&in_ready, latch in_data and go to WR_LO.
  - WR_LO: ram_we=1, ram_addr=ptr, ram_data=word[7:0]. Go to WR_HI.
  - WR_HI: ram_we=1, ram_addr=ptr+1, ram_data=word[15:8]. Then ptr+=2 and advance the counters.
    - Not the last word: in_ready=1. If a word is accepted, go to WR_LO; otherwise go to WAIT_WORD.
    - Last word: in_ready=0 and go to DONE.
  - DONE: done=1 for one cycle, load=0, then IDLE.
- Counter advance in WR_HI:
  - word_cnt increments.
  - At the end of a region (BIAS_WORDS-1 or WEIGHT_WORDS-1), word_cnt clears and region toggles.
  - At the end of the weights region, layer_idx increments.
- Last word: layer_idx==NUM_LAYERS-1, region=1, and word_cnt==WEIGHT_WORDS-1.
- Throughput: 2 cycles per word with continuous in_valid. Latency: first byte is written the cycle after the first accept.
- Layout is contiguous and little-endian: layer L bias, then layer L weights, then layer L+1.
- ptr wraps modulo 2^ADDR_W with no error flag. Sizing the layout to fit is the integrator's responsibility.
- in_valid outside WAIT_WORD/WR_HI, or while in_ready=0, is not consumed. The source must hold the word.
- ram_addr and ram_data are 0 whenever ram_we=0.
- Simultaneous events:
  - abort has priority over everything, including a handshake in the same cycle.
  - start during a load is ignored.
  - abort in IDLE is a no-op.
  - start and abort together in IDLE: stay in IDLE.
- Reset mid-load clears immediately; no further writes are issued.

Optional Feature:
- Macro: FC_PARAM_CHECKSUM_EN.
- Defined: checksum clears on start and adds each accepted word modulo 2^16 at the handshake. The value is held after done and until the next start or reset.
- Not defined: checksum is tied to 0 and no adder is built.

Test Plan:
- Default params except NUM_LAYERS=2, BIAS_WORDS=2, WEIGHT_WORDS=3, BASE_ADDR=0x0100.
  - start, then word 0x1234 → ram_we writes 0x34@0x0100 then 0x12@0x0101; layer_idx=0, region=0.
- Continuous in_valid with 10 words 0x0001..0x000A → 20 back-to-back write cycles; last write is 0x00@0x0113.
  - done pulses exactly 2 cycles after the final accept; load falls with done.
  - region toggles after words 2, 5 and 7; layer_idx becomes 1 after word 5.
- in_valid deasserted for 5 cycles mid-stream → controller sits in WAIT_WORD with ram_we=0; addresses resume contiguously.
- abort asserted after 3 words → IDLE next edge, load=0, no done; a new start rewrites from 0x0100.
- RST pulled low during WR_LO → all outputs 0 immediately; no write occurs after RST deasserts until start.
- With FC_PARAM_CHECKSUM_EN, words 0xFFFF, 0x0002 plus 8×0x0000 → checksum=0x0001 after done.

Source files
------------

// File: rtl/fc_param_load_ctrl.sv
// ---------------------------------------------------------------------------
// fc_param_load_ctrl
//
// Loads FC-layer parameters into a byte-wide parameter RAM. Words arrive on
// a 16-bit valid/ready stream. Each word becomes two byte writes, low byte
// first, at contiguous little-endian addresses. Each layer is laid out as its
// bias region followed by its weight region. The next layer follows directly.
//
// Handshake: a word moves only on a cycle where in_valid and in_ready are both
// high at the rising clock edge. in_ready never depends on in_data. in_ready is
// held low during a cycle with abort, so no word is consumed on an aborted
// cycle. The source must hold in_data stable until the word is accepted.
//
// Optional feature (macro FC_PARAM_CHECKSUM_EN): when defined, checksum is a
// running 16-bit sum of all words accepted since the last start. When not
// defined, checksum is tied to zero.
//
// Ports:
//   clk        rising-edge system clock
//   RST        asynchronous active-low reset
//   start      one-cycle load request (honoured only in IDLE)
//   abort      synchronous abort back to IDLE, no done pulse
//   in_data    16-bit parameter word
//   in_valid   in_data is valid
//   in_ready   controller accepts a word this cycle
//   ram_we     RAM byte write strobe
//   ram_addr   RAM byte address (0 when ram_we=0)
//   ram_data   RAM write byte (0 when ram_we=0)
//   load       a load is in progress
//   layer_idx  layer currently being loaded
//   region     0 = bias, 1 = weights
//   done       one-cycle pulse after the last byte is written
//   checksum   running word sum (see FC_PARAM_CHECKSUM_EN)
//   dbg_state  current FSM state encoding
// ---------------------------------------------------------------------------
module fc_param_load_ctrl #(
    parameter int                NUM_LAYERS   = 2,
    parameter int                BIAS_WORDS   = 10,
    parameter int                WEIGHT_WORDS = 100,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              load,
    output logic [7:0]        layer_idx,
    output logic              region,
    output logic              done,
    output logic [15:0]       checksum,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_WR_LO     = 3'd2,
        S_WR_HI     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [7:0]        LAST_LAYER  = 8'(NUM_LAYERS - 1);
    localparam logic [15:0]       BIAS_LAST   = 16'(BIAS_WORDS - 1);
    localparam logic [15:0]       WEIGHT_LAST = 16'(WEIGHT_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TWO    = ADDR_W'(2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       word_q, word_d;
    logic [7:0]        layer_q, layer_d;
    logic              region_q, region_d;
    logic [15:0]       cnt_q, cnt_d;

    logic last_word;
    logic region_end;
    logic start_load;

    // The word being written closes the whole load.
    assign last_word  = (layer_q == LAST_LAYER) && region_q && (cnt_q == WEIGHT_LAST);
    // The word being written is the final word of the current region.
    assign region_end = region_q ? (cnt_q == WEIGHT_LAST) : (cnt_q == BIAS_LAST);
    // Start is honoured only in IDLE. Abort in the same cycle cancels it.
    assign start_load = (state_q == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            ptr_q    <= BASE_ADDR;
            word_q   <= '0;
            layer_q  <= '0;
            region_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            word_q   <= word_d;
            layer_q  <= layer_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        word_d   = word_q;
        layer_d  = layer_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        load     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_load) begin
                    state_d  = S_WAIT_WORD;
                    ptr_d    = BASE_ADDR;
                    layer_d  = '0;
                    region_d = 1'b0;
                    cnt_d    = '0;
                end
            end

            S_WAIT_WORD: begin
                load = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        word_d  = in_data;
                        state_d = S_WR_LO;
                    end
                end
            end

            S_WR_LO: begin
                load     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = ptr_q;
                ram_data = word_q[7:0];
                state_d  = abort ? S_IDLE : S_WR_HI;
            end

            S_WR_HI: begin
                load     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = ptr_q + ADDR_ONE;
                ram_data = word_q[15:8];
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_TWO;
                    if (last_word) begin
                        // Counters stay on the final word so the last position stays visible.
                        state_d = S_DONE;
                    end else begin
                        if (region_end) begin
                            cnt_d    = '0;
                            region_d = ~region_q;
                            if (region_q) begin
                                layer_d = layer_q + 8'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        // Accepting the next word here keeps the stream at 2 cycles per word.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            word_d  = in_data;
                            state_d = S_WR_LO;
                        end else begin
                            state_d = S_WAIT_WORD;
                        end
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign layer_idx = layer_q;
    assign region    = region_q;
    assign dbg_state = state_q;

`ifdef FC_PARAM_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            csum_q <= '0;
        end else if (start_load) begin
            csum_q <= '0;
        end else if (in_valid && in_ready) begin
            csum_q <= csum_q + in_data;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule
